// File: rtl/program_loader_ctrl.sv
// Program loader: packs a byte stream into 32-bit imem writes while holding the core in reset,
// then releases the core and watches gp for riscv-tests completion or a cycle timeout.
module program_loader_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned IMEM_DEPTH     = 512,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] lenBytes,
  input  logic [7:0]       rxData,
  input  logic             rxValid,
  output logic             rxReady,
  output logic             cpuReset,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemAddr,
  output logic [WIDTH-1:0] insMemDataIn,
  input  logic [WIDTH-1:0] gp,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             overflow,
  output logic [WIDTH-1:0] failId,
  output logic [WIDTH-1:0] cycleCount
);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StRun, StDone} st_e;

  st_e              r_state;
  logic [WIDTH-1:0] r_len;
  logic [WIDTH-1:0] r_byte_cnt;
  logic [WIDTH-1:0] r_pack;
  logic             r_cpu_reset;
  logic             r_mem_en;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_data;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;
  logic             r_overflow;
  logic [WIDTH-1:0] r_fail_id;
  logic [WIDTH-1:0] r_cycle_count;

  logic [1:0]       w_lane;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_word_addr;
  logic             w_last;
  logic             w_oob;

  assign w_lane      = r_byte_cnt[1:0];
  assign w_word      = r_pack | (WIDTH'(rxData) << {w_lane, 3'b000});
  assign w_word_addr = {r_byte_cnt[WIDTH-1:2], 2'b00};
  assign w_last      = (r_byte_cnt == r_len - WIDTH'(1));
  // Any byte of the word landing past the end of imem suppresses the whole write.
  assign w_oob       = (w_word_addr + WIDTH'(3)) >= WIDTH'(IMEM_DEPTH);

  assign rxReady      = (r_state == StLoad);
  assign running      = (r_state == StRun);
  assign cpuReset     = r_cpu_reset;
  assign insMemEn     = r_mem_en;
  assign insMemAddr   = r_mem_addr;
  assign insMemDataIn = r_mem_data;
  assign done         = r_done;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign overflow     = r_overflow;
  assign failId       = r_fail_id;
  assign cycleCount   = r_cycle_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StIdle;
      r_len         <= '0;
      r_byte_cnt    <= '0;
      r_pack        <= '0;
      r_cpu_reset   <= 1'b1;
      r_mem_en      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_fail_id     <= '0;
      r_cycle_count <= '0;
    end else begin
      r_mem_en <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_len         <= lenBytes;
            r_byte_cnt    <= '0;
            r_pack        <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
            r_fail_id     <= '0;
            r_cycle_count <= '0;
            if (lenBytes != '0) begin
              r_state <= StLoad;
            end else begin
              r_state     <= StRun;
              r_cpu_reset <= 1'b0;
            end
          end
        end
        StLoad: begin
          if (rxValid) begin
            r_byte_cnt <= r_byte_cnt + WIDTH'(1);
            if (w_lane == 2'd3 || w_last) begin
              r_pack     <= '0;
              r_mem_addr <= w_word_addr;
              r_mem_data <= w_word;
              if (w_oob) r_overflow <= 1'b1;
              else       r_mem_en   <= 1'b1;
            end else begin
              r_pack <= w_word;
            end
            if (w_last) r_state <= StDrain;
          end
        end
        StDrain: begin
          r_state     <= StRun;
          r_cpu_reset <= 1'b0;
        end
        StRun: begin
          if (gp != '0) begin
            r_state     <= StDone;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b1;
            r_pass      <= (gp == WIDTH'(1));
            r_fail_id   <= gp >> 1;
            r_timeout   <= 1'b0;
          end else if (r_cycle_count == WIDTH'(TIMEOUT_CYCLES - 1)) begin
            r_state       <= StDone;
            r_cpu_reset   <= 1'b1;
            r_done        <= 1'b1;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b1;
            r_cycle_count <= WIDTH'(TIMEOUT_CYCLES);
          end else begin
            r_cycle_count <= r_cycle_count + WIDTH'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl: load/pack, back-pressure, pass/fail, timeout,
// overflow and mid-load reset, with hand-computed expectations.
module tb_program_loader_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] lenBytes;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        cpuReset;
  logic        insMemEn;
  logic [31:0] insMemAddr;
  logic [31:0] insMemDataIn;
  logic [31:0] gp;
  logic        running;
  logic        done;
  logic        pass;
  logic        timeout;
  logic        overflow;
  logic [31:0] failId;
  logic [31:0] cycleCount;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  program_loader_ctrl #(
    .WIDTH         (32),
    .IMEM_DEPTH    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .lenBytes    (lenBytes),
    .rxData      (rxData),
    .rxValid     (rxValid),
    .rxReady     (rxReady),
    .cpuReset    (cpuReset),
    .insMemEn    (insMemEn),
    .insMemAddr  (insMemAddr),
    .insMemDataIn(insMemDataIn),
    .gp          (gp),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .overflow    (overflow),
    .failId      (failId),
    .cycleCount  (cycleCount)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (insMemEn) begin
      wa.push_back(insMemAddr);
      wd.push_back(insMemDataIn);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Start a load and feed n bytes; with bp, rxValid idles every other cycle and is
  // also asserted with junk during the start cycle.
  task automatic load(input int n, input logic [7:0] b[12], input bit bp);
    int i = 0;
    int guard = 0;
    bit hs;
    wa.delete();
    wd.delete();
    start    = 1'b1;
    lenBytes = n;
    rxValid  = bp;
    rxData   = 8'hEE;
    @(negedge clock);
    start = 1'b0;
    while (i < n && guard < 200) begin
      if (bp && guard[0]) rxValid = 1'b0;
      else begin
        rxValid = 1'b1;
        rxData  = b[i];
      end
      hs = rxValid && rxReady;
      @(negedge clock);
      if (hs) i++;
      guard++;
    end
    rxValid = 1'b0;
    check("load_bytes_taken", i, n);
  endtask

  task automatic wait_run();
    int guard = 0;
    while (!running && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    check("run_entered", running, 1'b1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] a0,
                              input logic [31:0] d0, input logic [31:0] a1,
                              input logic [31:0] d1);
    check({tag, "_nwr"}, wa.size(), n);
    if (wa.size() >= 2) begin
      check({tag, "_a0"}, wa[0], a0);
      check({tag, "_d0"}, wd[0], d0);
      check({tag, "_a1"}, wa[1], a1);
      check({tag, "_d1"}, wd[1], d1);
    end
  endtask

  task automatic finish_gp(input int zeros, input logic [31:0] g);
    gp = '0;
    repeat (zeros) @(negedge clock);
    gp = g;
    @(negedge clock);
    gp = '0;
  endtask

  logic [7:0] prog8[12];
  logic [7:0] prog6[12];
  logic [7:0] prog12[12];

  initial begin
    prog8  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 0, 0, 0, 0};
    prog6  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 0, 0, 0, 0, 0, 0};
    prog12 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C};
    reset = 1'b1; start = 1'b0; lenBytes = '0; rxData = '0; rxValid = 1'b0; gp = '0;
    repeat (2) @(negedge clock);
    check("rst_cpuReset", cpuReset, 1'b1);
    check("rst_rxReady", rxReady, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_insMemEn", insMemEn, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Word load with DRAIN/cpuReset timing
    load(8, prog8, 1'b0);
    check("drain_cpuReset", cpuReset, 1'b1);
    check("drain_rxReady", rxReady, 1'b0);
    check("drain_insMemEn", insMemEn, 1'b1);
    @(negedge clock);
    check("run_cpuReset", cpuReset, 1'b0);
    check("run_cycle0", cycleCount, 0);
    check_writes("w8", 2, 0, 32'h0000_0013, 4, 32'h0010_0093);
    finish_gp(10, 32'd1);
    check("pass_done", done, 1'b1);
    check("pass_pass", pass, 1'b1);
    check("pass_cycles", cycleCount, 10);
    check("pass_cpuReset", cpuReset, 1'b1);

    // Partial word, then fail result
    load(6, prog6, 1'b0);
    wait_run();
    check_writes("w6", 2, 0, 32'hDDCC_BBAA, 4, 32'h0000_FFEE);
    finish_gp(3, 32'd7);
    check("fail_done", done, 1'b1);
    check("fail_pass", pass, 1'b0);
    check("fail_id", failId, 3);
    check("fail_timeout", timeout, 1'b0);

    // Back-pressure, then timeout
    load(8, prog8, 1'b1);
    wait_run();
    check_writes("wbp", 2, 0, 32'h0000_0013, 4, 32'h0010_0093);
    begin
      int guard = 0;
      while (!done && guard < 40) begin
        @(negedge clock);
        guard++;
      end
    end
    check("to_done", done, 1'b1);
    check("to_timeout", timeout, 1'b1);
    check("to_pass", pass, 1'b0);
    check("to_cycles", cycleCount, 16);

    // Overflow: third word lies past 8-byte imem
    load(12, prog12, 1'b0);
    wait_run();
    check_writes("wov", 2, 0, 32'h0403_0201, 4, 32'h0807_0605);
    check("ov_flag", overflow, 1'b1);
    finish_gp(2, 32'd1);
    check("ov_done", done, 1'b1);

    // Zero-length start goes straight to RUN with cleared flags
    start = 1'b1; lenBytes = 0;
    @(negedge clock);
    start = 1'b0;
    check("zl_running", running, 1'b1);
    check("zl_overflow", overflow, 1'b0);
    check("zl_done", done, 1'b0);
    finish_gp(1, 32'd1);

    // Reset mid-load, then clean reload
    wa.delete(); wd.delete();
    start = 1'b1; lenBytes = 8;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxValid = 1'b1; rxData = prog8[i];
      @(negedge clock);
    end
    rxValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mr_cpuReset", cpuReset, 1'b1);
    check("mr_rxReady", rxReady, 1'b0);
    check("mr_nwr", wa.size(), 0);
    check("mr_done", done, 1'b0);
    @(negedge clock);
    load(8, prog8, 1'b0);
    wait_run();
    check_writes("wmr", 2, 0, 32'h0000_0013, 4, 32'h0010_0093);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
